// File: rtl/sq_pkg.sv
// Shared types and pointer helpers for the store queue.
// Pointers carry one wrap bit above the index bits, so with aw index bits a pointer is aw+1 bits wide.
package sq_pkg;

  typedef struct packed {
    logic valid;
    logic addr_ok;
    logic committed;
  } sq_flags_t;

  // Advance a pointer by one, wrapping at 2*DEPTH.
  function automatic int unsigned ptr_inc(int unsigned p, int unsigned aw);
    return (p + 1) & ((32'd1 << (aw + 1)) - 1);
  endfunction

  // Physical entry index of a pointer (the wrap bit is dropped).
  function automatic int unsigned ptr_idx(int unsigned p, int unsigned aw);
    return p & ((32'd1 << aw) - 1);
  endfunction

  // True when physical index i lies in the pointer window [lo, hi).
  function automatic bit ptr_in_range(int unsigned i, int unsigned lo, int unsigned hi,
                                      int unsigned aw);
    int unsigned off;
    int unsigned n;
    off = (i - lo) & ((32'd1 << aw) - 1);
    n   = (hi - lo) & ((32'd1 << (aw + 1)) - 1);
    return off < n;
  endfunction

endpackage

// File: rtl/store_queue_fwd_if.sv
// Dispatch / AGU / commit / drain / forwarding signals of the store queue.
interface store_queue_fwd_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 6
);
  logic                      dispatch_valid;
  logic [ROB_W-1:0]          dispatch_rob_idx;
  logic                      dispatch_ready;
  logic [$clog2(DEPTH):0]    dispatch_sq_idx;
  logic                      exec_valid;
  logic [$clog2(DEPTH)-1:0]  exec_sq_idx;
  logic [ADDR_W-1:0]         exec_addr;
  logic [DATA_W-1:0]         exec_data;
  logic                      commit_valid;
  logic                      flush;
  logic                      mem_req_valid;
  logic [ADDR_W-1:0]         mem_req_addr;
  logic [DATA_W-1:0]         mem_req_data;
  logic                      mem_req_ready;
  logic                      ld_valid;
  logic [ADDR_W-1:0]         ld_addr;
  logic [$clog2(DEPTH):0]    ld_sq_tail;
  logic                      fwd_hit;
  logic [DATA_W-1:0]         fwd_data;
  logic                      fwd_stall;
  logic [$clog2(DEPTH):0]    count;
  logic                      empty;

  // The store queue itself.
  modport slave (
    input  dispatch_valid, dispatch_rob_idx, exec_valid, exec_sq_idx, exec_addr, exec_data,
           commit_valid, flush, mem_req_ready, ld_valid, ld_addr, ld_sq_tail,
    output dispatch_ready, dispatch_sq_idx, mem_req_valid, mem_req_addr, mem_req_data,
           fwd_hit, fwd_data, fwd_stall, count, empty
  );

  // The surrounding pipeline.
  modport master (
    output dispatch_valid, dispatch_rob_idx, exec_valid, exec_sq_idx, exec_addr, exec_data,
           commit_valid, flush, mem_req_ready, ld_valid, ld_addr, ld_sq_tail,
    input  dispatch_ready, dispatch_sq_idx, mem_req_valid, mem_req_addr, mem_req_data,
           fwd_hit, fwd_data, fwd_stall, count, empty
  );
endinterface

// File: rtl/sq_fwd_search.sv
// Youngest-first priority search over the stores older than a load.
// span is the number of entries between head and the load's tail snapshot.
module sq_fwd_search #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [$clog2(DEPTH):0]   ld_tail,
  input  logic [$clog2(DEPTH):0]   span,
  input  logic                     ent_valid [DEPTH],
  input  logic                     ent_ok    [DEPTH],
  input  logic [ADDR_W-1:0]        ent_addr  [DEPTH],
  output logic                     fwd_hit,
  output logic                     fwd_stall,
  output logic [$clog2(DEPTH)-1:0] fwd_idx
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic          done;
  logic [AW-1:0] idx;

  // Walk from ld_tail-1 downwards; the first unresolved address or matching address decides.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_idx   = '0;
    done      = 1'b0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = AW'(ld_tail - PW'(k + 1));
      if (ld_valid && !done && (PW'(k) < span) && ent_valid[idx]) begin
        if (!ent_ok[idx]) begin
          fwd_stall = 1'b1;
          done      = 1'b1;
        end else if (ent_addr[idx] == ld_addr) begin
          fwd_hit = 1'b1;
          fwd_idx = idx;
          done    = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/store_queue_fwd.sv
// Store queue: holds stores from dispatch to retirement, drains committed stores to memory,
// forwards store data to younger loads and squashes uncommitted stores on flush.
module store_queue_fwd
  import sq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 6
) (
  input logic              clk,
  input logic              reset,
  store_queue_fwd_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [AW-1:0] idx_t;

  ptr_t head, cmt, tail, cmt_post, count_w, ld_span, ld_n;
  idx_t hidx, cidx, tidx, fwd_idx;
  logic full, do_disp, do_cmt, do_drain, exec_ok, fwd_hit_w;

  sq_flags_t         flg            [DEPTH];
  logic [ADDR_W-1:0] ent_addr       [DEPTH];
  logic [DATA_W-1:0] ent_data       [DEPTH];
  // ROB tag is kept alongside the entry for debug visibility; nothing in this block reads it.
  logic [ROB_W-1:0]  ent_rob_unused [DEPTH];
  logic              ent_valid      [DEPTH];
  logic              ent_ok         [DEPTH];

  assign hidx    = idx_t'(ptr_idx(32'(head), AW));
  assign cidx    = idx_t'(ptr_idx(32'(cmt), AW));
  assign tidx    = idx_t'(ptr_idx(32'(tail), AW));
  assign count_w = tail - head;
  assign full    = (count_w == PW'(DEPTH));

  assign bus.count           = count_w;
  assign bus.empty           = (count_w == '0);
  assign bus.dispatch_ready  = !full;
  assign bus.dispatch_sq_idx = tail;
  assign bus.mem_req_valid   = flg[hidx].valid && flg[hidx].committed && flg[hidx].addr_ok;
  assign bus.mem_req_addr    = ent_addr[hidx];
  assign bus.mem_req_data    = ent_data[hidx];

  // A dispatch that coincides with a flush belongs to the squashed path and is dropped.
  assign do_disp  = bus.dispatch_valid && !full && !bus.flush;
  assign do_cmt   = bus.commit_valid && (cmt != tail);
  assign do_drain = bus.mem_req_valid && bus.mem_req_ready;
  assign exec_ok  = bus.exec_valid && flg[bus.exec_sq_idx].valid
                    && !flg[bus.exec_sq_idx].committed;
  assign cmt_post = do_cmt ? ptr_t'(ptr_inc(32'(cmt), AW)) : cmt;

  // Stores older than a load's snapshot; a snapshot behind head means all of them drained.
  assign ld_span = bus.ld_sq_tail - head;
  assign ld_n    = (ld_span <= count_w) ? ld_span : '0;

  // Flatten the flags for the search block.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = flg[i].valid;
      ent_ok[i]    = flg[i].addr_ok;
    end
  end

  // Pointers and per-entry flags; a flush squashes [cmt_post, tail) after the same-cycle commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) flg[i] <= '0;
    end else begin
      cmt <= cmt_post;
      if (do_drain) head <= ptr_t'(ptr_inc(32'(head), AW));
      if (bus.flush)    tail <= cmt_post;
      else if (do_disp) tail <= ptr_t'(ptr_inc(32'(tail), AW));
      for (int i = 0; i < DEPTH; i++) begin
        if (exec_ok && (bus.exec_sq_idx == idx_t'(i))) flg[i].addr_ok   <= 1'b1;
        if (do_cmt && (cidx == idx_t'(i)))             flg[i].committed <= 1'b1;
        if (do_disp && (tidx == idx_t'(i)))
          flg[i] <= '{valid: 1'b1, addr_ok: 1'b0, committed: 1'b0};
        if (do_drain && (hidx == idx_t'(i)))           flg[i].valid <= 1'b0;
        if (bus.flush && ptr_in_range(32'(i), 32'(cmt_post), 32'(tail), AW))
          flg[i].valid <= 1'b0;
      end
    end
  end

  // Entry payload; qualified by the flags, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (exec_ok && (bus.exec_sq_idx == idx_t'(i))) begin
        ent_addr[i] <= bus.exec_addr;
        ent_data[i] <= bus.exec_data;
      end
      if (do_disp && (tidx == idx_t'(i))) ent_rob_unused[i] <= bus.dispatch_rob_idx;
    end
  end

  sq_fwd_search #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_search (
    .ld_valid  (bus.ld_valid),
    .ld_addr   (bus.ld_addr),
    .ld_tail   (bus.ld_sq_tail),
    .span      (ld_n),
    .ent_valid (ent_valid),
    .ent_ok    (ent_ok),
    .ent_addr  (ent_addr),
    .fwd_hit   (fwd_hit_w),
    .fwd_stall (bus.fwd_stall),
    .fwd_idx   (fwd_idx)
  );

  assign bus.fwd_hit  = fwd_hit_w;
  assign bus.fwd_data = fwd_hit_w ? ent_data[fwd_idx] : '0;
endmodule

// File: tb/tb_store_queue_fwd.sv
// Directed bench for store_queue_fwd with a queue-based reference model checked every cycle.
module tb_store_queue_fwd;
  localparam int D = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  store_queue_fwd_if #(.DEPTH(D), .ADDR_W(32), .DATA_W(32), .ROB_W(6)) bus ();

  store_queue_fwd #(.DEPTH(D), .ADDR_W(32), .DATA_W(32), .ROB_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: program-order list of live stores, oldest first.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          exe;
    bit          cmt;
  } ms_t;
  ms_t mq[$];
  int  mhead = 0;
  bit  live = 1'b0;
  int  cyc = 0;
  logic [31:0] log_addr[$];
  int          log_cyc[$];

  function automatic void mfwd(output bit hit, output bit stall, output logic [31:0] d);
    int n;
    hit = 1'b0; stall = 1'b0; d = '0;
    if (!bus.ld_valid) return;
    n = (int'(bus.ld_sq_tail) - mhead + 16) % 16;
    if (n > mq.size()) n = 0;
    for (int j = n - 1; j >= 0; j--) begin
      if (!mq[j].exe) begin stall = 1'b1; return; end
      if (mq[j].addr == bus.ld_addr) begin hit = 1'b1; d = mq[j].data; return; end
    end
  endfunction

  always @(posedge clk) begin
    bit drain, disp;
    cyc++;
    if (reset) begin
      mq.delete();
      mhead = 0;
      live  = 1'b1;
    end else if (live) begin
      drain = mq.size() > 0 && mq[0].exe && mq[0].cmt && bus.mem_req_ready;
      disp  = bus.dispatch_valid && mq.size() < D && !bus.flush;
      if (bus.exec_valid)
        for (int j = 0; j < mq.size(); j++)
          if ((mhead + j) % D == int'(bus.exec_sq_idx) && !mq[j].cmt) begin
            mq[j].exe  = 1'b1;
            mq[j].addr = bus.exec_addr;
            mq[j].data = bus.exec_data;
          end
      if (bus.commit_valid)
        for (int j = 0; j < mq.size(); j++)
          if (!mq[j].cmt) begin mq[j].cmt = 1'b1; break; end
      if (bus.flush)
        for (int j = mq.size() - 1; j >= 0; j--)
          if (!mq[j].cmt) mq.delete(j);
      if (drain) begin
        void'(mq.pop_front());
        mhead = (mhead + 1) % 16;
      end
      if (disp) mq.push_back('{addr: 32'h0, data: 32'h0, exe: 1'b0, cmt: 1'b0});
    end
  end

  always @(negedge clk) begin
    bit eh, es, emv;
    logic [31:0] ed;
    if (live && !reset) begin
      emv = mq.size() > 0 && mq[0].exe && mq[0].cmt;
      chk("count", bus.count, mq.size());
      chk("empty", bus.empty, mq.size() == 0);
      chk("dispatch_ready", bus.dispatch_ready, mq.size() < D);
      chk("dispatch_sq_idx", bus.dispatch_sq_idx, (mhead + mq.size()) % 16);
      chk("mem_req_valid", bus.mem_req_valid, emv);
      if (emv) begin
        chk("mem_req_addr", bus.mem_req_addr, mq[0].addr);
        chk("mem_req_data", bus.mem_req_data, mq[0].data);
      end
      mfwd(eh, es, ed);
      chk("fwd_hit", bus.fwd_hit, eh);
      chk("fwd_stall", bus.fwd_stall, es);
      if (eh) chk("fwd_data", bus.fwd_data, ed);
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        log_addr.push_back(bus.mem_req_addr);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dispatch_valid = 0; bus.dispatch_rob_idx = '0;
    bus.exec_valid = 0; bus.exec_sq_idx = '0; bus.exec_addr = '0; bus.exec_data = '0;
    bus.commit_valid = 0; bus.flush = 0; bus.mem_req_ready = 0;
    bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_sq_tail = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic disp(input int rob);
    bus.dispatch_valid = 1'b1;
    bus.dispatch_rob_idx = 6'(rob);
    tick();
    bus.dispatch_valid = 1'b0;
  endtask

  task automatic exec(input int idx, input logic [31:0] a, input logic [31:0] d);
    bus.exec_valid = 1'b1; bus.exec_sq_idx = 3'(idx); bus.exec_addr = a; bus.exec_data = d;
    tick();
    bus.exec_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, ne, nc, last, cur;
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_ready", bus.dispatch_ready, 1);
    chk("rst_mem_valid", bus.mem_req_valid, 0);
    chk("rst_fwd_hit", bus.fwd_hit, 0);
    chk("rst_fwd_stall", bus.fwd_stall, 0);
    chk("rst_sq_idx", bus.dispatch_sq_idx, 0);

    // Fill to DEPTH; the ninth dispatch must be refused.
    for (int i = 0; i < 8; i++) disp(i);
    chk("fill_count", bus.count, 8);
    chk("fill_ready", bus.dispatch_ready, 0);
    disp(9);
    chk("fill_tail", bus.dispatch_sq_idx, 8);
    chk("fill_count9", bus.count, 8);

    // Ordered drain on consecutive cycles.
    do_reset();
    disp(0); disp(1); disp(2);
    exec(0, 32'h100, 32'hA); exec(1, 32'h104, 32'hB); exec(2, 32'h108, 32'hC);
    log_addr.delete(); log_cyc.delete();
    bus.mem_req_ready = 1'b1;
    bus.commit_valid = 1'b1;
    tick(); tick(); tick();
    bus.commit_valid = 1'b0;
    tick(); tick();
    chk("ord_n", log_addr.size(), 3);
    if (log_addr.size() >= 3) begin
      chk("ord_a0", log_addr[0], 32'h100);
      chk("ord_a1", log_addr[1], 32'h104);
      chk("ord_a2", log_addr[2], 32'h108);
      chk("ord_gap1", log_cyc[1] - log_cyc[0], 1);
      chk("ord_gap2", log_cyc[2] - log_cyc[1], 1);
    end
    chk("ord_empty", bus.empty, 1);
    bus.mem_req_ready = 1'b0;

    // Forwarding picks the youngest older match.
    do_reset();
    disp(0); disp(1);
    exec(0, 32'h200, 32'h11); exec(1, 32'h200, 32'h22);
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h200; bus.ld_sq_tail = 4'd2;
    #1 chk("fwd_both_hit", bus.fwd_hit, 1);
    chk("fwd_both_data", bus.fwd_data, 32'h22);
    bus.ld_sq_tail = 4'd1;
    #1 chk("fwd_first_data", bus.fwd_data, 32'h11);
    bus.ld_sq_tail = 4'd0;
    #1 chk("fwd_none_hit", bus.fwd_hit, 0);
    chk("fwd_none_stall", bus.fwd_stall, 0);
    tick();
    bus.ld_sq_tail = 4'd2;
    bus.exec_valid = 1'b1; bus.exec_sq_idx = 3'd1; bus.exec_addr = 32'h999; bus.exec_data = 32'h99;
    #1 chk("fwd_same_cycle_exec", bus.fwd_data, 32'h22);
    tick();
    bus.exec_valid = 1'b0;
    #1 chk("fwd_after_exec", bus.fwd_data, 32'h11);
    bus.ld_valid = 1'b0;

    // Unresolved older store forces a stall.
    do_reset();
    disp(0); disp(1);
    exec(1, 32'h300, 32'h33);
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h300; bus.ld_sq_tail = 4'd1;
    #1 chk("stall_stall", bus.fwd_stall, 1);
    chk("stall_hit", bus.fwd_hit, 0);
    bus.ld_sq_tail = 4'd2;
    #1 chk("young_hit", bus.fwd_hit, 1);
    chk("young_stall", bus.fwd_stall, 0);
    chk("young_data", bus.fwd_data, 32'h33);
    bus.ld_valid = 1'b0;

    // Reset while a request is pending discards it.
    do_reset();
    disp(0);
    exec(0, 32'h500, 32'h55);
    bus.commit_valid = 1'b1;
    tick();
    bus.commit_valid = 1'b0;
    chk("rmd_valid_before", bus.mem_req_valid, 1);
    reset = 1'b1; bus.mem_req_ready = 1'b1;
    tick();
    reset = 1'b0; bus.mem_req_ready = 1'b0;
    chk("rmd_valid_after", bus.mem_req_valid, 0);
    chk("rmd_count", bus.count, 0);

    // Flush with a same-cycle commit and dispatch.
    do_reset();
    for (int i = 0; i < 5; i++) disp(i);
    for (int i = 0; i < 5; i++) exec(i, 32'h400 + 32'(4 * i), 32'(i));
    bus.commit_valid = 1'b1;
    tick(); tick();
    bus.flush = 1'b1; bus.dispatch_valid = 1'b1;
    tick();
    idle();
    chk("flush_tail", bus.dispatch_sq_idx, 3);
    chk("flush_count", bus.count, 3);
    log_addr.delete(); log_cyc.delete();
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.mem_req_ready = 1'b0;
    chk("flush_drain_n", log_addr.size(), 3);
    if (log_addr.size() >= 3) begin
      chk("flush_a0", log_addr[0], 32'h400);
      chk("flush_a1", log_addr[1], 32'h404);
      chk("flush_a2", log_addr[2], 32'h408);
    end
    chk("flush_final_count", bus.count, 0);

    // Wrap-around stream with a toggling ready.
    do_reset();
    log_addr.delete(); log_cyc.delete();
    nd = 0; ne = 0; nc = 0; last = -1;
    for (int c = 0; c < 400 && log_addr.size() < 20; c++) begin
      bus.mem_req_ready = (c % 2 == 0);
      bus.exec_valid = (last >= 0);
      if (last >= 0) begin
        bus.exec_sq_idx = 3'(last % 8);
        bus.exec_addr = 32'h1000 + 32'(4 * last);
        bus.exec_data = 32'(last) ^ 32'h5A;
      end
      bus.commit_valid = (nc < ne);
      if (nd < 20 && bus.dispatch_ready) begin
        bus.dispatch_valid = 1'b1; bus.dispatch_rob_idx = 6'(nd);
        cur = nd; nd++;
      end else begin
        bus.dispatch_valid = 1'b0;
        cur = -1;
      end
      tick();
      if (bus.exec_valid) ne++;
      if (bus.commit_valid) nc++;
      last = cur;
    end
    idle();
    chk("wrap_n", log_addr.size(), 20);
    for (int k = 0; k < 20; k++)
      if (k < log_addr.size()) chk("wrap_addr", log_addr[k], 32'h1000 + 32'(4 * k));
    chk("wrap_count", bus.count, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/store_queue_fwd.md
# store_queue_fwd

Parametrised store queue for the Jellycore out-of-order back end. It holds stores from dispatch to retirement, captures their executed address and data, and drains committed stores to the data-memory port with a valid/ready handshake. It also answers same-cycle store-to-load forwarding queries and squashes uncommitted stores on a pipeline flush. It sits between dispatch/ROB, the store AGU, the load unit and the D-cache write port.

## Interface
- DEPTH, 8, number of entries; power of two, ≥ 2
- ADDR_W, 32, address width
- DATA_W, 32, store data width
- ROB_W, 6, ROB index width
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- dispatch_valid  in  1  allocate entry at tail
- dispatch_rob_idx  in  ROB_W  ROB tag of the store
- dispatch_ready  out  1  entry available (= !full)
- dispatch_sq_idx  out  log2(DEPTH)+1  tail pointer (with wrap bit) handed to the store; also the load's age snapshot
- exec_valid  in  1  AGU result for one entry
- exec_sq_idx  in  log2(DEPTH)  target entry
- exec_addr  in  ADDR_W  computed address
- exec_data  in  DATA_W  store data
- commit_valid  in  1  ROB retires the oldest uncommitted store
- flush  in  1  squash all uncommitted entries
- mem_req_valid  out  1  head entry ready to write
- mem_req_addr  out  ADDR_W  head address
- mem_req_data  out  DATA_W  head data
- mem_req_ready  in  1  memory accepts the request
- ld_valid  in  1  forwarding query
- ld_addr  in  ADDR_W  load address
- ld_sq_tail  in  log2(DEPTH)+1  tail snapshot taken at load dispatch
- fwd_hit  out  1  forward fwd_data to the load
- fwd_data  out  DATA_W  forwarded data
- fwd_stall  out  1  an older store has an unknown address; load must retry
- count  out  log2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- Per-entry state: valid, addr_ok, committed, rob_idx, addr, data.
- Three pointers, each log2(DEPTH)+1 bits with a wrap bit: head (drain), cmt (next to commit), tail (allocate). Invariant: head ≤ cmt ≤ tail in modular order.
- count = tail − head. full = (count == DEPTH).
- Dispatch: when dispatch_valid && dispatch_ready:
  - write valid=1, addr_ok=0, committed=0 and rob_idx at tail;
  - tail+1.
- Exec: when exec_valid, set addr/data/addr_ok on entry exec_sq_idx. Ignored if that entry is not valid or is already committed.
- Commit: when commit_valid && cmt != tail, set committed on entry cmt and advance cmt+1. A commit with no uncommitted entries is ignored.
- Drain: mem_req_valid = head entry valid && committed && addr_ok. On mem_req_valid && mem_req_ready, clear valid and advance head+1.
- Flush:
  - commit in the same cycle is applied first;
  - then tail ← cmt (post-commit), and every entry from cmt to old tail gets valid cleared;
  - dispatch in the same cycle is dropped;
  - drain continues unaffected.
- Forwarding (combinational, only when ld_valid):
  - scan entries from ld_sq_tail−1 down to head, youngest first;
  - the first entry with addr_ok=0 → fwd_stall=1, fwd_hit=0;
  - otherwise the first entry with addr == ld_addr → fwd_hit=1, fwd_data = that entry's data;
  - no match → both 0;
  - matching is full-word only, with no byte masking.

## Timing
- Reset values: all pointers 0, count 0, empty 1, all entry valid 0, dispatch_ready 1, mem_req_valid 0, fwd_hit 0, fwd_stall 0.
- dispatch_ready, mem_req_*, count, empty and dispatch_sq_idx are derived from registered state. A drain does not make dispatch_ready rise in the same cycle.
- Simultaneous dispatch and drain: count is unchanged. When full, dispatch waits one cycle after the drain.
- Exec→drain: an entry whose exec and commit both arrive in cycle N can raise mem_req_valid in N+1 at the earliest.
- Forward outputs are valid in the same cycle as ld_valid and reflect only state registered before that edge. An exec arriving in the same cycle is not visible.
- Wrap-around: the pointer index is pointer[log2(DEPTH)−1:0]. full vs. empty is distinguished by the wrap bit.
- Reset asserted mid-drain: mem_req_valid is 0 in the next cycle and queued stores are discarded.

## Structure
- Package sq_pkg holds the entry typedef (parametrised widths passed as module parameters) and pointer-arithmetic helper functions (ptr_inc, ptr_idx, ptr_in_range).
- Sub-module sq_fwd_search: a purely combinational youngest-first priority search, producing fwd_hit, fwd_stall and the selected index.
- The top level holds the pointers, entry array and handshake logic.

## Test plan
- Fill: 8 dispatches with no drain → count=8, dispatch_ready=0. A 9th dispatch is ignored and tail is unchanged.
- Ordered drain:
  - dispatch 3 stores;
  - exec them with addresses 0x100/0x104/0x108 and data 0xA/0xB/0xC;
  - commit all 3, hold mem_req_ready=1;
  - required: requests appear in order 0x100, 0x104, 0x108 on consecutive cycles, then empty=1.
- Forwarding:
  - two stores to 0x200 with data 0x11 then 0x22, both executed;
  - load at 0x200 with ld_sq_tail after both → fwd_hit=1, fwd_data=0x22;
  - ld_sq_tail after the first only → fwd_data=0x11.
- Stall: an older store is not yet executed and a younger store to 0x300 has executed. A load at 0x300 with a snapshot covering only the older store → fwd_stall=1, fwd_hit=0.
- Flush:
  - 5 entries, 2 committed, flush asserted together with a 3rd commit;
  - required: tail = cmt = 3, count=3;
  - a dispatch in the same cycle is dropped;
  - the 3 committed entries still drain.
- Wrap: 20 dispatch/exec/commit/drain cycles with mem_req_ready toggling 1/0 → all 20 addresses are written in order with no loss, and the final count=0.
